// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_SEQ    = 3'd0,
    OP_JUMP   = 3'd1,
    OP_BRANCH = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4,
    OP_HOLD   = 3'd5
  } pc_op_t;

  localparam int ERR_ALIGN = 0;
  localparam int ERR_OVF   = 1;
  localparam int ERR_UNF   = 2;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-unit <-> sequencer bus: op request in, pc and status out.
interface pc_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic [2:0]       op;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus;
  logic             ras_empty;
  logic             ras_full;
  logic [2:0]       err;

  modport master (
    output en, op, target, offset,
    input  pc, pc_plus, ras_empty, ras_full, err
  );

  modport slave (
    input  en, op, target, offset,
    output pc, pc_plus, ras_empty, ras_full, err
  );
endinterface

// File: rtl/pc_ras.sv
// Return-address stack: circular top pointer with a saturating count, so a
// push while full silently overwrites the oldest entry.
module pc_ras #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             overflow
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  assign empty    = (cnt_q == {CW{1'b0}});
  assign full     = (cnt_q == DEPTH_C);
  assign overflow = push & full;
  assign top      = mem_q[ptr_q];

  // Next pointer/count; push wins if both are asserted, pop on empty is a no-op.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = ptr_q + PW'(1);
      if (!full) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (pop && !empty) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end else begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
    end
  end

  // Stack state and storage.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      ptr_q <= {PW{1'b0}};
      cnt_q <= {CW{1'b0}};
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (push) begin
        mem_q[ptr_d] <= push_data;
      end
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// Program counter with increment, jump, relative branch, call/return via an
// internal return-address stack, stall, and sticky error flags.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                     WIDTH        = 32,
  parameter int                     STEP         = 4,
  parameter logic [WIDTH-1:0]       RESET_VECTOR = '0,
  parameter int                     RAS_DEPTH    = 4
) (
  input  logic clk,
  input  logic clr_n,
  pc_sequencer_if.slave bus
);
  localparam logic [WIDTH-1:0] STEP_C     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [2:0]       err_q, err_d;
  logic [WIDTH-1:0] pc_plus_s;
  logic [WIDTH-1:0] addr_s;
  logic             chk_align_s;
  logic             push_s, pop_s;
  logic [WIDTH-1:0] ras_top_s;
  logic             ras_empty_s, ras_full_s, ras_ovf_s;

  assign pc_plus_s = pc_q + STEP_C;

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .clr_n     (clr_n),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (pc_plus_s),
    .top       (ras_top_s),
    .empty     (ras_empty_s),
    .full      (ras_full_s),
    .overflow  (ras_ovf_s)
  );

  // Next-pc selection; targets from JUMP/CALL/BRANCH are forced onto STEP alignment.
  always_comb begin
    pc_d        = pc_q;
    err_d       = err_q;
    addr_s      = {WIDTH{1'b0}};
    chk_align_s = 1'b0;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    if (bus.en) begin
      case (bus.op)
        OP_SEQ: pc_d = pc_plus_s;
        OP_JUMP: begin
          addr_s      = bus.target;
          chk_align_s = 1'b1;
        end
        OP_BRANCH: begin
          addr_s      = pc_q + bus.offset;
          chk_align_s = 1'b1;
        end
        OP_CALL: begin
          addr_s      = bus.target;
          chk_align_s = 1'b1;
          push_s      = 1'b1;
          if (ras_ovf_s) begin
            err_d[ERR_OVF] = 1'b1;
          end else begin
            err_d[ERR_OVF] = err_q[ERR_OVF];
          end
        end
        OP_RET: begin
          if (ras_empty_s) begin
            pc_d           = pc_plus_s;
            err_d[ERR_UNF] = 1'b1;
          end else begin
            pc_d  = ras_top_s;
            pop_s = 1'b1;
          end
        end
        default: pc_d = pc_q;
      endcase
      if (chk_align_s) begin
        pc_d = addr_s & ~ALIGN_MASK;
        if ((addr_s & ALIGN_MASK) != {WIDTH{1'b0}}) begin
          err_d[ERR_ALIGN] = 1'b1;
        end else begin
          err_d[ERR_ALIGN] = err_q[ERR_ALIGN];
        end
      end else begin
        addr_s = {WIDTH{1'b0}};
      end
    end else begin
      pc_d  = pc_q;
      err_d = err_q;
    end
  end

  // Architectural state.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      pc_q  <= RESET_VECTOR;
      err_q <= 3'b000;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_plus   = pc_plus_s;
  assign bus.ras_empty = ras_empty_s;
  assign bus.ras_full  = ras_full_s;
  assign bus.err       = err_q;
endmodule
